// File: rtl/mux25_rr_arbiter.sv
// mux25_rr_arbiter
//   Round-robin arbiter that shares one 25-bit operand path, made of a 2:1 mux
//   followed by a multi-cycle unit, between two requesters A and B.
//   The winner's operand is latched into dout and sel is driven toward the mux.
//   A one-cycle start pulse is issued to the unit. The arbiter then waits for
//   done and returns a one-cycle ack to the winner.
//   Optional watchdog: define MUX25_ARB_TIMEOUT_EN. When it is defined, a
//   transfer that sees no done for TIMEOUT WAIT cycles is aborted with ack+err.
//   When it is undefined, no counter exists and err is constant 0.
//   All outputs come straight from registers.
module mux25_rr_arbiter #(
    parameter int WIDTH   = 25,
    parameter int TIMEOUT = 15,   // legal range 1 .. 2**CNT_W-1
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] din_b,
    output logic             sel,
    output logic [WIDTH-1:0] dout,
    output logic             start,
    input  logic             done,
    output logic             ack_a,
    output logic             ack_b,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             sel_reg, sel_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             start_reg, start_next;
    logic             ack_a_reg, ack_a_next;
    logic             ack_b_reg, ack_b_next;
    logic             err_reg, err_next;
    logic             busy_reg, busy_next;
    logic             last_reg, last_next;      // last served: 0=A, 1=B
    logic             elig_a, elig_b, winner;

`ifdef MUX25_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    // State and output registers; reset returns to IDLE with the pointer on B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            dout_reg  <= '0;
            start_reg <= 1'b0;
            ack_a_reg <= 1'b0;
            ack_b_reg <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            last_reg  <= 1'b1;
`ifdef MUX25_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            dout_reg  <= dout_next;
            start_reg <= start_next;
            ack_a_reg <= ack_a_next;
            ack_b_reg <= ack_b_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
            last_reg  <= last_next;
`ifdef MUX25_ARB_TIMEOUT_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    // Next-state logic: arbitration in IDLE, start in ISSUE, completion or abort in WAIT.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        dout_next  = dout_reg;
        last_next  = last_reg;
        start_next = 1'b0;
        ack_a_next = 1'b0;
        ack_b_next = 1'b0;
        err_next   = 1'b0;
`ifdef MUX25_ARB_TIMEOUT_EN
        cnt_next   = cnt_reg;
`endif
        // A requester whose ack is being shown right now still holds a stale
        // req. Masking it stops the same side from being granted twice in a row.
        elig_a = req_a & ~ack_a_reg;
        elig_b = req_b & ~ack_b_reg;
        winner = (elig_a & elig_b) ? ~last_reg : elig_b;

        case (state_reg)
            IDLE: begin
                if (elig_a | elig_b) begin
                    sel_next   = winner;
                    dout_next  = winner ? din_b : din_a;
                    last_next  = winner;
                    start_next = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
`ifdef MUX25_ARB_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            WAIT: begin
                if (done) begin
                    ack_a_next = ~sel_reg;
                    ack_b_next = sel_reg;
                    state_next = IDLE;
                end
`ifdef MUX25_ARB_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    ack_a_next = ~sel_reg;
                    ack_b_next = sel_reg;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign sel   = sel_reg;
    assign dout  = dout_reg;
    assign start = start_reg;
    assign ack_a = ack_a_reg;
    assign ack_b = ack_b_reg;
    assign err   = err_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_mux25_rr_arbiter.sv
// tb_mux25_rr_arbiter
//   Directed bench for mux25_rr_arbiter. It exercises single grants, ties,
//   sustained contention and reset in the middle of WAIT. When
//   MUX25_ARB_TIMEOUT_EN is defined it also covers the watchdog abort and the
//   race between done and the watchdog. When the macro is undefined it covers
//   an indefinite WAIT instead.
module tb_mux25_rr_arbiter;

    localparam int WIDTH = 25;

    logic             clk = 1'b0;
    logic             rst, req_a, req_b, done;
    logic [WIDTH-1:0] din_a, din_b, dout;
    logic             sel, start, ack_a, ack_b, err, busy;

    int n_checks = 0;
    int n_errors = 0;

    mux25_rr_arbiter #(.WIDTH(WIDTH), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .din_a (din_a),
        .req_b (req_b),
        .din_b (din_b),
        .sel   (sel),
        .dout  (dout),
        .start (start),
        .done  (done),
        .ack_a (ack_a),
        .ack_b (ack_b),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step one clock; outputs are then sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step clocks until start is seen, up to limit cycles; returns cycles taken.
    task automatic wait_start(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!start && n < limit);
        check("start_seen", start, 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int  n;
    logic exp_sel;
    logic busy_all, err_any;

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done = 1'b0;
        din_a = '0; din_b = '0;
        tick();
        tick();
        // Reset state.
        check("rst_sel",   sel,   0);
        check("rst_dout",  dout,  0);
        check("rst_start", start, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_err",   err,   0);
        check("rst_busy",  busy,  0);
        rst = 1'b0;

        // 1: single A request, done three cycles after start.
        req_a = 1'b1; din_a = 25'h1ABCDEF;
        tick();
        check("t1_start", start, 1);
        check("t1_sel",   sel,   0);
        check("t1_dout",  dout,  32'h1ABCDEF);
        check("t1_busy",  busy,  1);
        din_a = 25'h0000000;                       // source may move on after start
        tick();
        check("t1_start_once", start, 0);
        check("t1_dout_held",  dout,  32'h1ABCDEF);
        tick();
        tick();
        done = 1'b1;
        check("t1_no_early_ack", ack_a, 0);
        tick();
        check("t1_ack_a", ack_a, 1);
        check("t1_ack_b", ack_b, 0);
        check("t1_err",   err,   0);
        done = 1'b0; req_a = 1'b0;
        tick();
        check("t1_ack_pulse", ack_a, 0);
        check("t1_busy_low",  busy,  0);
        check("t1_no_start",  start, 0);
        $display("t1 single A: sel=%0d dout=%h", sel, dout);

        // 2: tie right after reset, A first then B; A's stale req is masked.
        reset_pulse();
        req_a = 1'b1; req_b = 1'b1; din_a = 25'h0000001; din_b = 25'h1FFFFFF;
        tick();
        check("t2_start_a", start, 1);
        check("t2_sel_a",   sel,   0);
        check("t2_dout_a",  dout,  32'h0000001);
        tick();
        done = 1'b1;
        tick();
        check("t2_ack_a", ack_a, 1);
        done = 1'b0;                               // req_a still high here
        tick();
        check("t2_start_b", start, 1);
        check("t2_sel_b",   sel,   1);
        check("t2_dout_b",  dout,  32'h1FFFFFF);
        check("t2_ack_a_clr", ack_a, 0);
        req_a = 1'b0;
        tick();
        done = 1'b1;
        tick();
        check("t2_ack_b", ack_b, 1);
        check("t2_err",   err,   0);
        done = 1'b0; req_b = 1'b0;
        tick();
        check("t2_idle", busy, 0);
        $display("t2 tie: A then B granted");

        // 3: both held for six operations; strict alternation, next start at done+2.
        req_a = 1'b1; req_b = 1'b1; din_a = 25'h0AAAAAA; din_b = 25'h1555555;
        exp_sel = 1'b0;                            // pointer is B, so A goes first
        for (int i = 0; i < 6; i++) begin
            wait_start(6, n);
            if (i > 0) check("t3_gap", n, 1);
            check("t3_sel",  sel,  exp_sel);
            check("t3_dout", dout, exp_sel ? 32'h1555555 : 32'h0AAAAAA);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check("t3_ack_a", ack_a, !exp_sel);
            check("t3_ack_b", ack_b, exp_sel);
            $display("t3 op %0d: sel=%0d dout=%h", i, sel, dout);
            exp_sel = ~exp_sel;
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();

        // 4: reset during WAIT of a B grant, then a tie goes to A.
        reset_pulse();
        req_b = 1'b1; din_b = 25'h0123456;
        tick();
        check("t4_sel_b", sel, 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t4_async_busy", busy, 0);
        check("t4_async_sel",  sel,  0);
        check("t4_async_dout", dout, 0);
        check("t4_async_err",  err,  0);
        tick();
        check("t4_no_ack_b", ack_b, 0);
        rst = 1'b0;
        req_a = 1'b1; din_a = 25'h0FEDCBA;
        tick();
        check("t4_tie_start", start, 1);
        check("t4_tie_sel",   sel,   0);
        check("t4_tie_dout",  dout,  32'h0FEDCBA);
        req_b = 1'b0;
        tick();
        done = 1'b1;
        tick();
        check("t4_ack_a", ack_a, 1);
        done = 1'b0; req_a = 1'b0;
        tick();
        $display("t4 reset mid-WAIT: A granted after release");

`ifdef MUX25_ARB_TIMEOUT_EN
        // 5: no done at all -> abort with err after 15 WAIT cycles.
        req_a = 1'b1; din_a = 25'h1234567;
        tick();
        check("t5_start", start, 1);
        busy_all = 1'b1; err_any = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            busy_all &= busy;
            err_any  |= (err | ack_a);
        end
        check("t5_wait_busy",   busy_all, 1);
        check("t5_wait_no_ack", err_any,  0);
        tick();
        check("t5_ack_a", ack_a, 1);
        check("t5_err",   err,   1);
        check("t5_idle",  busy,  0);
        req_a = 1'b0;
        tick();
        check("t5_err_pulse", err, 0);
        $display("t5 watchdog abort: err seen");

        // 6: done on the 15th WAIT cycle beats the watchdog.
        req_a = 1'b1;
        tick();
        check("t6_start", start, 1);
        for (int k = 1; k <= 14; k++) tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t6_ack_a", ack_a, 1);
        check("t6_err",   err,   0);
        req_a = 1'b0;
        tick();
        $display("t6 watchdog race: done wins");
`else
        // 6: without the watchdog, WAIT holds indefinitely.
        req_a = 1'b1; din_a = 25'h1234567;
        tick();
        check("t6_start", start, 1);
        busy_all = 1'b1; err_any = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            busy_all &= busy;
            err_any  |= (err | ack_a);
        end
        check("t6_busy_held", busy_all, 1);
        check("t6_no_err",    err_any,  0);
        reset_pulse();
        req_a = 1'b0;
        tick();
        $display("t6 no watchdog: WAIT held 100 cycles");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
